alu_seq: RTL

- Parametrised, registered successor to the processor's combinational ALU.
- Accepts one operation per cycle over a valid/ready handshake and registers the result and status flags.
- Adds shifts and an iterative shift-add multiplier; the multiplier blocks new input while it runs.
- Sits between the register-file read stage and write-back in the RISC datapath.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand/result bus for alu_seq: valid/ready operand side plus registered result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             zflag;
  logic             carryflag;
  logic             overflowflag;
  logic             signflag;
  logic             err;

  modport master (
    output in_valid, in1, in2, alu_control,
    input  in_ready, out, out_valid, zflag, carryflag, overflowflag, signflag, err
  );

  modport slave (
    input  in_valid, in1, in2, alu_control,
    output in_ready, out, out_valid, zflag, carryflag, overflowflag, signflag, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with shifts and an optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to enable opcode 9 (MUL); otherwise opcode 9 is illegal.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL
  } op_e;

  logic [WIDTH-1:0] out_q, res_d;
  logic             z_q, c_q, v_q, s_q, err_q, ov_q;
  logic             c_d, v_d, err_d, accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_e;
  state_e             state_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               is_mul;

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign acc_d        = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign bus.in_ready = !rst;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign sh     = bus.in2[SHW-1:0];

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
  always_comb begin
    add_w = {1'b0, bus.in1} + {1'b0, bus.in2};
    sub_w = {1'b0, bus.in1} - {1'b0, bus.in2};
    sll_w = {1'b0, bus.in1} << sh;
    srl_w = {bus.in1, 1'b0} >> sh;
    sra_w = $signed({bus.in1, 1'b0}) >>> sh;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    is_mul = 1'b0;
`endif
    case (bus.alu_control)
      OP_ADD: begin
        res_d = add_w[WIDTH-1:0];
        c_d   = add_w[WIDTH];
        v_d   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (add_w[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_w[WIDTH-1:0];
        c_d   = sub_w[WIDTH];
        v_d   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (sub_w[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_AND: res_d = bus.in1 & bus.in2;
      OP_OR:  res_d = bus.in1 | bus.in2;
      OP_XOR: res_d = bus.in1 ^ bus.in2;
      OP_NOR: res_d = ~(bus.in1 | bus.in2);
      OP_SLL: begin
        res_d = sll_w[WIDTH-1:0];
        c_d   = sll_w[WIDTH];
      end
      OP_SRL: begin
        res_d = srl_w[WIDTH:1];
        c_d   = srl_w[0];
      end
      OP_SRA: begin
        res_d = sra_w[WIDTH:1];
        c_d   = sra_w[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      s_q   <= 1'b0;
      err_q <= 1'b0;
      ov_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      ov_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      if (state_q == MUL_BUSY) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          out_q   <= acc_d[WIDTH-1:0];
          z_q     <= (acc_d[WIDTH-1:0] == '0);
          c_q     <= |acc_d[2*WIDTH-1:WIDTH];
          v_q     <= 1'b0;
          s_q     <= acc_d[WIDTH-1];
          err_q   <= 1'b0;
          ov_q    <= 1'b1;
          state_q <= IDLE;
        end
      end else if (accept && is_mul) begin
        state_q  <= MUL_BUSY;
        acc_q    <= '0;
        cnt_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, bus.in1};
        mplier_q <= bus.in2;
      end else
`endif
      if (accept) begin
        out_q <= res_d;
        z_q   <= (res_d == '0);
        c_q   <= c_d;
        v_q   <= v_d;
        s_q   <= res_d[WIDTH-1];
        err_q <= err_d;
        ov_q  <= 1'b1;
      end
    end
  end

  assign bus.out          = out_q;
  assign bus.out_valid    = ov_q;
  assign bus.zflag        = z_q;
  assign bus.carryflag    = c_q;
  assign bus.overflowflag = v_q;
  assign bus.signflag     = s_q;
  assign bus.err          = err_q;
endmodule
